// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and busy-bit scoreboard for the RV32I register file.
// Merges ALU and load results onto one registered write port and stalls issue on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clkin,
  input  logic            nrst_in,
  input  logic            issue_valid_in,
  input  logic [4:0]      issue_rd_in,
  input  logic [4:0]      issue_rs1_in,
  input  logic [4:0]      issue_rs2_in,
  output logic            issue_ready_out,
  input  logic            ex_valid_in,
  input  logic [4:0]      ex_idx_in,
  input  logic [XLEN-1:0] ex_data_in,
  output logic            ex_ready_out,
  input  logic            ld_valid_in,
  input  logic [4:0]      ld_idx_in,
  input  logic [XLEN-1:0] ld_data_in,
  output logic            ld_ready_out,
  output logic            wr_en_out,
  output logic [4:0]      wr_idx_out,
  output logic [XLEN-1:0] wr_data_out,
  output logic [31:0]     busy_out,
  output logic            err_out
);

  logic [31:1]     busy_q;
  logic [31:0]     busy;
  logic [31:1]     busy_set;
  logic [31:1]     busy_clr;
  logic            rr_ptr_q;
  logic            issue_fire;
  logic            grant_ex;
  logic            grant_ld;
  logic            grant;
  logic [4:0]      grant_idx;
  logic [XLEN-1:0] grant_data;
  logic            err_hit;

  assign busy     = {busy_q, 1'b0};
  assign busy_out = busy;

  // rd is included so a second writer to a pending register waits (WAW)
  assign issue_ready_out = ~(busy[issue_rs1_in] | busy[issue_rs2_in] | busy[issue_rd_in]);
  assign issue_fire      = issue_valid_in & issue_ready_out;

  always_comb begin
    grant_ex = 1'b0;
    grant_ld = 1'b0;
    if (RR_EN) begin
      if (ex_valid_in && ld_valid_in) begin
        grant_ex = ~rr_ptr_q;
        grant_ld = rr_ptr_q;
      end else begin
        grant_ex = ex_valid_in;
        grant_ld = ld_valid_in;
      end
    end else begin
      grant_ld = ld_valid_in;
      grant_ex = ex_valid_in & ~ld_valid_in;
    end
  end

  assign ex_ready_out = grant_ex;
  assign ld_ready_out = grant_ld;
  assign grant        = grant_ex | grant_ld;
  assign grant_idx    = grant_ld ? ld_idx_in  : ex_idx_in;
  assign grant_data   = grant_ld ? ld_data_in : ex_data_in;

  // A register being issued this same cycle counts as legitimately pending
  assign err_hit = grant && (grant_idx != 5'd0) && !busy[grant_idx] &&
                   !(issue_fire && (issue_rd_in == grant_idx));

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int i = 1; i < 32; i++) begin
      busy_set[i] = issue_fire && (issue_rd_in == 5'(i));
      busy_clr[i] = wr_en_out && (wr_idx_out == 5'(i));
    end
  end

  // Set has priority over clear: the newer issue still owes a write
  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_set | (busy_q & ~busy_clr);
    end
  end

  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      rr_ptr_q <= 1'b0;
    end else if (grant_ex) begin
      rr_ptr_q <= 1'b1;
    end else if (grant_ld) begin
      rr_ptr_q <= 1'b0;
    end
  end

  // Writes to x0 are accepted from the requester but never reach the port
  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      wr_en_out   <= 1'b0;
      wr_idx_out  <= 5'd0;
      wr_data_out <= '0;
    end else begin
      wr_en_out <= grant && (grant_idx != 5'd0);
      if (grant && (grant_idx != 5'd0)) begin
        wr_idx_out  <= grant_idx;
        wr_data_out <= grant_data;
      end
    end
  end

  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      err_out <= 1'b0;
    end else if (err_hit) begin
      err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: one round-robin instance and one fixed-priority instance.
module tb_regfile_wb_sched;

  logic        clkin;
  logic        nrst_in;
  logic        issue_valid_in;
  logic [4:0]  issue_rd_in, issue_rs1_in, issue_rs2_in;
  logic        ex_valid_in, ld_valid_in;
  logic [4:0]  ex_idx_in, ld_idx_in;
  logic [31:0] ex_data_in, ld_data_in;
  logic        f_ex_valid, f_ld_valid;

  logic        issue_ready, ex_ready, ld_ready, wr_en, err;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data, busy;
  logic        f_issue_ready, f_ex_ready, f_ld_ready, f_wr_en, f_err;
  logic [4:0]  f_wr_idx;
  logic [31:0] f_wr_data, f_busy;

  int tests = 0;
  int fails = 0;

  regfile_wb_sched #(.XLEN(32), .RR_EN(1'b1)) dut (
    .clkin(clkin), .nrst_in(nrst_in),
    .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
    .issue_rs1_in(issue_rs1_in), .issue_rs2_in(issue_rs2_in),
    .issue_ready_out(issue_ready),
    .ex_valid_in(ex_valid_in), .ex_idx_in(ex_idx_in), .ex_data_in(ex_data_in),
    .ex_ready_out(ex_ready),
    .ld_valid_in(ld_valid_in), .ld_idx_in(ld_idx_in), .ld_data_in(ld_data_in),
    .ld_ready_out(ld_ready),
    .wr_en_out(wr_en), .wr_idx_out(wr_idx), .wr_data_out(wr_data),
    .busy_out(busy), .err_out(err)
  );

  regfile_wb_sched #(.XLEN(32), .RR_EN(1'b0)) dut_fp (
    .clkin(clkin), .nrst_in(nrst_in),
    .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
    .issue_rs1_in(issue_rs1_in), .issue_rs2_in(issue_rs2_in),
    .issue_ready_out(f_issue_ready),
    .ex_valid_in(f_ex_valid), .ex_idx_in(ex_idx_in), .ex_data_in(ex_data_in),
    .ex_ready_out(f_ex_ready),
    .ld_valid_in(f_ld_valid), .ld_idx_in(ld_idx_in), .ld_data_in(ld_data_in),
    .ld_ready_out(f_ld_ready),
    .wr_en_out(f_wr_en), .wr_idx_out(f_wr_idx), .wr_data_out(f_wr_data),
    .busy_out(f_busy), .err_out(f_err)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_in = 0; issue_rd_in = 0; issue_rs1_in = 0; issue_rs2_in = 0;
    ex_valid_in = 0; ex_idx_in = 0; ex_data_in = 0;
    ld_valid_in = 0; ld_idx_in = 0; ld_data_in = 0;
    f_ex_valid = 0; f_ld_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clkin);
    #1 nrst_in = 0;
    #2 nrst_in = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst_in = 0;
    #12 nrst_in = 1;
    tick();
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got %h exp %h", busy, 32'h0); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    tests++; if (wr_idx !== 5'd0) begin fails++; $display("FAIL reset_wr_idx got %0d exp 0", wr_idx); end
    tests++; if (wr_data !== 32'h0) begin fails++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
  endtask

  task automatic test_raw_stall();
    issue_valid_in = 1; issue_rd_in = 5;
    #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL raw_c0_ready got %b exp 1", issue_ready); end
    tick();
    issue_rd_in = 0; issue_rs1_in = 5;
    #1;
    tests++; if (busy[5] !== 1'b1) begin fails++; $display("FAIL raw_c1_busy5 got %b exp 1", busy[5]); end
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL raw_c1_ready got %b exp 0", issue_ready); end
    tick();
    tick();
    ex_valid_in = 1; ex_idx_in = 5; ex_data_in = 32'hDEADBEEF;
    #1;
    tests++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL raw_c3_ex_ready got %b exp 1", ex_ready); end
    tick();
    ex_valid_in = 0;
    #1;
    tests++; if ({wr_en, wr_idx} !== {1'b1, 5'd5}) begin fails++; $display("FAIL raw_c4_wr got en=%b idx=%0d exp en=1 idx=5", wr_en, wr_idx); end
    tests++; if (wr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL raw_c4_data got %h exp deadbeef", wr_data); end
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL raw_c4_ready got %b exp 0", issue_ready); end
    tick();
    #1;
    tests++; if (busy[5] !== 1'b0) begin fails++; $display("FAIL raw_c5_busy5 got %b exp 0", busy[5]); end
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL raw_c5_ready got %b exp 1", issue_ready); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL raw_c5_wr_en got %b exp 0", wr_en); end
    idle_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    issue_valid_in = 1; issue_rd_in = 3;
    tick();
    issue_rd_in = 4;
    tick();
    issue_valid_in = 0; issue_rd_in = 0;
    ex_valid_in = 1; ex_idx_in = 3; ex_data_in = 32'h33;
    ld_valid_in = 1; ld_idx_in = 4; ld_data_in = 32'h44;
    f_ex_valid = 1; f_ld_valid = 1;
    #1;
    tests++; if ({ex_ready, ld_ready} !== 2'b10) begin fails++; $display("FAIL rr_first_grant got ex=%b ld=%b exp ex=1 ld=0", ex_ready, ld_ready); end
    tests++; if ({f_ex_ready, f_ld_ready} !== 2'b01) begin fails++; $display("FAIL fp_first_grant got ex=%b ld=%b exp ex=0 ld=1", f_ex_ready, f_ld_ready); end
    tick();
    ex_valid_in = 0; f_ld_valid = 0;
    #1;
    tests++; if (wr_idx !== 5'd3) begin fails++; $display("FAIL rr_seq0 got %0d exp 3", wr_idx); end
    tests++; if (f_wr_idx !== 5'd4) begin fails++; $display("FAIL fp_seq0 got %0d exp 4", f_wr_idx); end
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL rr_second_grant got %b exp 1", ld_ready); end
    tests++; if (f_ex_ready !== 1'b1) begin fails++; $display("FAIL fp_second_grant got %b exp 1", f_ex_ready); end
    tick();
    idle_inputs();
    #1;
    tests++; if ({wr_en, wr_idx, wr_data} !== {1'b1, 5'd4, 32'h44}) begin fails++; $display("FAIL rr_seq1 got en=%b idx=%0d data=%h exp en=1 idx=4 data=44", wr_en, wr_idx, wr_data); end
    tests++; if ({f_wr_en, f_wr_idx, f_wr_data} !== {1'b1, 5'd3, 32'h33}) begin fails++; $display("FAIL fp_seq1 got en=%b idx=%0d data=%h exp en=1 idx=3 data=33", f_wr_en, f_wr_idx, f_wr_data); end
    tick();
    tests++; if ({busy, f_busy} !== 64'h0) begin fails++; $display("FAIL rr_busy_drained got %h/%h exp 0/0", busy, f_busy); end
    tests++; if ({err, f_err} !== 2'b00) begin fails++; $display("FAIL rr_err got %b/%b exp 0/0", err, f_err); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ex_seq [4];
    logic [4:0] ld_seq [4];
    logic       exv_seq [4];
    logic       exr_exp [4];
    logic [4:0] wr_exp [4];
    ex_seq = '{5'd1, 5'd2, 5'd2, 5'd0};
    exv_seq = '{1'b1, 1'b1, 1'b1, 1'b0};
    ld_seq = '{5'd3, 5'd3, 5'd4, 5'd4};
    exr_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    wr_exp = '{5'd1, 5'd3, 5'd2, 5'd4};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue_valid_in = 1; issue_rd_in = 5'(i);
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      ex_valid_in = exv_seq[c]; ex_idx_in = ex_seq[c]; ex_data_in = 32'(ex_seq[c]) + 32'h100;
      ld_valid_in = 1'b1; ld_idx_in = ld_seq[c]; ld_data_in = 32'(ld_seq[c]) + 32'h200;
      #1;
      tests++; if (ex_ready !== exr_exp[c]) begin fails++; $display("FAIL b2b_ex_ready[%0d] got %b exp %b", c, ex_ready, exr_exp[c]); end
      tick();
      tests++; if ({wr_en, wr_idx} !== {1'b1, wr_exp[c]}) begin fails++; $display("FAIL b2b_wr[%0d] got en=%b idx=%0d exp en=1 idx=%0d", c, wr_en, wr_idx, wr_exp[c]); end
    end
    idle_inputs();
    tick();
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL b2b_busy got %h exp 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err got %b exp 0", err); end
  endtask

  task automatic test_x0();
    issue_valid_in = 1; issue_rd_in = 0;
    tick();
    issue_valid_in = 0;
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL x0_busy got %h exp 0", busy); end
    ld_valid_in = 1; ld_idx_in = 0; ld_data_in = 32'h55;
    #1;
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL x0_ld_ready got %b exp 1", ld_ready); end
    tick();
    idle_inputs();
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL x0_wr_en got %b exp 0", wr_en); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL x0_err got %b exp 0", err); end
    tick();
  endtask

  task automatic test_spurious_and_collision();
    ex_valid_in = 1; ex_idx_in = 9; ex_data_in = 32'h99;
    tick();
    idle_inputs();
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL spur_err got %b exp 1", err); end
    tests++; if ({wr_en, wr_idx, wr_data} !== {1'b1, 5'd9, 32'h99}) begin fails++; $display("FAIL spur_write got en=%b idx=%0d data=%h exp en=1 idx=9 data=99", wr_en, wr_idx, wr_data); end
    tick();
    ex_valid_in = 1; ex_idx_in = 7; ex_data_in = 32'h77;
    tick();
    idle_inputs();
    issue_valid_in = 1; issue_rd_in = 7;
    #1;
    tests++; if ({wr_en, wr_idx, issue_ready} !== {1'b1, 5'd7, 1'b1}) begin fails++; $display("FAIL coll_setup got en=%b idx=%0d ready=%b exp en=1 idx=7 ready=1", wr_en, wr_idx, issue_ready); end
    tick();
    idle_inputs();
    #1;
    tests++; if (busy[7] !== 1'b1) begin fails++; $display("FAIL coll_busy7 got %b exp 1", busy[7]); end
    tick();
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL spur_sticky got %b exp 1", err); end
  endtask

  task automatic test_reset_mid_write();
    issue_valid_in = 1; issue_rd_in = 5;
    tick();
    idle_inputs();
    ex_valid_in = 1; ex_idx_in = 5; ex_data_in = 32'h1234;
    tick();
    idle_inputs();
    #1;
    tests++; if ({wr_en, busy[5], err} !== 3'b111) begin fails++; $display("FAIL mid_pre got en=%b busy5=%b err=%b exp 1/1/1", wr_en, busy[5], err); end
    nrst_in = 0;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL mid_wr_en got %b exp 0", wr_en); end
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL mid_busy got %h exp 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL mid_err got %b exp 0", err); end
    #1 nrst_in = 1;
    tick();
    tick();
    tests++; if ({wr_en, err} !== 2'b00) begin fails++; $display("FAIL mid_after got en=%b err=%b exp 0/0", wr_en, err); end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_round_robin();
    test_back_to_back();
    test_x0();
    test_spurious_and_collision();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and scoreboard for the RV32I register file. It arbitrates two write-back requesters onto the register file's single write port: the execute/ALU path (`ex`) and the load unit (`ld`). It tracks a busy bit per architectural register for every accepted-but-not-yet-written destination, and stalls instruction issue on RAW/WAW hazards. It sits between the issue stage, the two result producers, and the register file write port (`wr_en` / `wr_idx` / `wr_data`).

## Interface
- `XLEN`, default 32: data width of write-back values.
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, `ld` over `ex`.
- `clkin` input 1: clock; all state updates on the rising edge.
- `nrst_in` input 1: reset, asynchronous, active-low.
- `issue_valid_in` input 1: issue stage presents an instruction.
- `issue_rd_in` input 5: destination register index; 0 means no write.
- `issue_rs1_in`, `issue_rs2_in` input 5 each: source register indices; 0 is never busy.
- `issue_ready_out` output 1: instruction may issue this cycle (combinational).
- `ex_valid_in` input 1, `ex_idx_in` input 5, `ex_data_in` input XLEN: ALU write-back request.
- `ex_ready_out` output 1: ex request granted this cycle (combinational).
- `ld_valid_in` input 1, `ld_idx_in` input 5, `ld_data_in` input XLEN: load write-back request.
- `ld_ready_out` output 1: ld request granted this cycle (combinational).
- `wr_en_out` output 1, `wr_idx_out` output 5, `wr_data_out` output XLEN: registered register file write port.
- `busy_out` output 32: scoreboard vector; bit 0 is always 0.
- `err_out` output 1: sticky flag for a write-back to a non-busy register.

## Operation
**Scoreboard**
- `busy[31:1]` are flops; `busy[0]` is tied to 0.
- Issue acceptance: `issue_fire = issue_valid_in & issue_ready_out`.
- `issue_ready_out = ~(busy[rs1] | busy[rs2] | busy[rd])`. This is independent of `issue_valid_in`.
- On `issue_fire` with rd≠0, `busy[rd]` is set at the clock edge.

**Arbitration**
- At most one grant per cycle. The output port is registered, so it is always free.
- Only one requester valid: grant it.
- Both valid with `RR_EN=1`: grant the one selected by the pointer `rr_ptr` (0=ex, 1=ld).
- Both valid with `RR_EN=0`: always grant `ld`.
- `rr_ptr` flips to the non-granted side after every grant and holds when there is no grant.
- `x_ready_out` is asserted only in the cycle `x` is granted. A requester holds valid, idx and data until granted.

**Write-back**
- A grant with idx≠0 loads `wr_en_out=1`, `wr_idx_out=idx`, `wr_data_out=data` at the next edge.
- A grant with idx=0 is accepted but dropped: `wr_en_out=0` next cycle.
- No grant: `wr_en_out=0`. `wr_idx_out` and `wr_data_out` hold their last value.
- `busy[wr_idx_out]` clears at the edge where `wr_en_out=1`, i.e. the same edge the register file captures the data.

**Error flag**
- `err_out` sets when a grant targets idx≠0 whose busy bit is 0 and which is not being set by `issue_fire` in the same cycle.
- It clears only on reset.

**Simultaneous events**
- Set and clear of the same busy bit in one cycle (issue rd == `wr_idx_out` with `wr_en_out=1`): set wins, because a newer write is pending.
- Issue reading a register whose clear occurs this cycle: `issue_ready_out` is still 0 this cycle; issue succeeds the next cycle.

**Reset**
- Asynchronous, any time, including mid-transfer.
- `busy_out=0`, `wr_en_out=0`, `wr_idx_out=0`, `wr_data_out=0`, `err_out=0`, `rr_ptr=0` (ex).
- Pending requests are not remembered.

## Timing
- Grant at cycle N leads to `wr_en_out` high during N+1, with the register file written at the end of N+1.
- The busy bit clears at that same edge, and a dependent instruction can issue in N+2.
- Issue-to-busy latency: 1 edge.
- `issue_ready_out`, `ex_ready_out` and `ld_ready_out` are combinational from inputs and flops. There is no path from `*_valid_in` to `issue_ready_out`.
- Sustained throughput: one write-back per cycle.
- With `RR_EN=1`, two continuously valid requesters alternate strictly.

## Test plan
- **Reset mid-write:** assert `nrst_in` low while `wr_en_out=1` and `busy[5]=1` → `wr_en_out`, `busy_out` and `err_out` go to 0 immediately, without waiting for a clock edge.
- **RAW stall:** issue rd=5 at cycle 0; at cycle 1 issue rs1=5 → `issue_ready_out=0`. Present `ex` idx=5, data=0xDEADBEEF at cycle 3 → `ex_ready_out=1` at cycle 3; cycle 4 has `wr_en_out=1`, `wr_idx_out=5`, `wr_data_out=0xDEADBEEF`; at cycle 5 `busy[5]=0` and `issue_ready_out=1`.
- **Round-robin:** `ex` (idx 3) and `ld` (idx 4) both valid with both registers busy, after reset → grant ex at cycle 0 and ld at cycle 1; `wr_idx_out` sequence is 3, 4. With `RR_EN=0` the sequence is 4, 3.
- **x0 handling:** issue rd=0 → no busy bit set. `ld` write-back to idx 0 → `ld_ready_out=1`, `wr_en_out` stays 0, `err_out` stays 0.
- **Set/clear collision:** `wr_en_out=1` to idx 7 while issuing rd=7 in the same cycle → `busy[7]` remains 1.
- **Spurious write:** `ex` write-back to idx 9 with `busy[9]=0` → `err_out=1` next cycle and stays 1 until reset; the write still occurs.
